// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Pure declarations: no latency, no backpressure.
package hazard_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } mc_state_t;

  // W-port codes sit after the NWP M-port codes: W port k = NWP + FWD_W0 + k.
  localparam int FWD_RF = 0;
  localparam int FWD_M0 = 1;
  localparam int FWD_W0 = 1;

  // r15 reads return PC+8 from the datapath, so it must never be forwarded.
  localparam int PC_REG = 15;

  function automatic int fwd_m_code(input int k);
    return FWD_M0 + k;
  endfunction

  function automatic int fwd_w_code(input int nwp, input int k);
    return nwp + FWD_W0 + k;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_fwd_select.sv
// Forward-select for a single E-stage operand: M ports beat W ports, lower port wins.
// Latency: combinational; no backpressure.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int NWP = 2,
  parameter int AW  = 4,
  parameter int SW  = $clog2(2*NWP+1)
) (
  input  logic [AW-1:0]     src_addr,
  input  logic              src_valid,
  input  logic [NWP*AW-1:0] dst_addr_m,
  input  logic [NWP-1:0]    wr_en_m,
  input  logic [NWP*AW-1:0] dst_addr_w,
  input  logic [NWP-1:0]    wr_en_w,
  output logic [SW-1:0]     sel
);

  logic not_pc;
  assign not_pc = (src_addr != AW'(PC_REG));

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    sel = SW'(FWD_RF);
    if (src_valid && not_pc) begin
      for (int k = NWP-1; k >= 0; k--) begin
        if (wr_en_w[k] && (dst_addr_w[k*AW +: AW] == src_addr)) begin
          sel = SW'(fwd_w_code(NWP, k));
        end
      end
      for (int k = NWP-1; k >= 0; k--) begin
        if (wr_en_m[k] && (dst_addr_m[k*AW +: AW] == src_addr)) begin
          sel = SW'(fwd_m_code(k));
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, multicycle E hold, perf counters.
// Latency: control outputs combinational, counters update next cycle; no backpressure.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int NWP    = 2,
  parameter int AW     = 4,
  parameter int MC_LAT = 3,
  parameter int CNT_W  = 16,
  localparam int SW    = $clog2(2*NWP+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC*AW-1:0]  src_addr_d,
  input  logic [NSRC-1:0]     src_valid_d,
  input  logic [NSRC*AW-1:0]  src_addr_e,
  input  logic [NSRC-1:0]     src_valid_e,
  input  logic [NWP*AW-1:0]   dst_addr_e,
  input  logic [NWP*AW-1:0]   dst_addr_m,
  input  logic [NWP*AW-1:0]   dst_addr_w,
  input  logic [NWP-1:0]      wr_en_e,
  input  logic [NWP-1:0]      wr_en_m,
  input  logic [NWP-1:0]      wr_en_w,
  input  logic                mem_to_reg_e,
  input  logic                mc_start_e,
  input  logic                branch_taken_e,
  input  logic [2:0]          pc_wr_pending,
  input  logic                pcsrc_w,
  output logic [NSRC*SW-1:0]  fwd_sel_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_m,
  output logic                mc_hold,
  output logic [CNT_W-1:0]    cnt_ldstall,
  output logic [CNT_W-1:0]    cnt_mcstall,
  output logic [CNT_W-1:0]    cnt_flush,
  input  logic                cnt_clr
);

  localparam int CW = $clog2(MC_LAT+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  genvar g;
  for (g = 0; g < NSRC; g++) begin : g_fwd
    fwd_select #(
      .NWP(NWP),
      .AW (AW),
      .SW (SW)
    ) u_fwd (
      .src_addr  (src_addr_e[g*AW +: AW]),
      .src_valid (src_valid_e[g]),
      .dst_addr_m(dst_addr_m),
      .wr_en_m   (wr_en_m),
      .dst_addr_w(dst_addr_w),
      .wr_en_w   (wr_en_w),
      .sel       (fwd_sel_e[g*SW +: SW])
    );
  end

  logic ld_hit;
  logic ldstall;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < NWP; j++) begin
        if (src_valid_d[i] && wr_en_e[j] &&
            (src_addr_d[i*AW +: AW] == dst_addr_e[j*AW +: AW])) begin
          ld_hit = 1'b1;
        end
      end
    end
  end

  assign ldstall = mem_to_reg_e & ld_hit;

  mc_state_t       state_q, state_d;
  logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
  logic            mc_hold_raw;

  // DONE is the release cycle: the held instruction leaves E, so a start seen there is stale.
  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    mc_hold_raw = 1'b0;
    case (state_q)
      IDLE: begin
        mc_hold_raw = mc_start_e && (MC_LAT > 1);
        if (mc_start_e) begin
          if (MC_LAT > 2) begin
            state_d  = BUSY;
            mc_cnt_d = CW'(MC_LAT - 2);
          end else if (MC_LAT == 2) begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        mc_hold_raw = 1'b1;
        mc_cnt_d    = mc_cnt_q - CW'(1);
        if (mc_cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  logic pc_pend;

  assign mc_hold = mc_hold_raw & ~reset;
  assign pc_pend = |pc_wr_pending;

  assign stall_f = ldstall | pc_pend | mc_hold;
  assign stall_d = ldstall | mc_hold;
  assign flush_d = pc_pend | pcsrc_w | branch_taken_e;
  assign flush_e = (ldstall | branch_taken_e) & ~mc_hold;
  assign flush_m = mc_hold;

  // Counter index: 0 = load-use stall, 1 = multicycle stall, 2 = flush.
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            cnt_inc;

  assign cnt_inc[0] = ldstall & ~mc_hold;
  assign cnt_inc[1] = mc_hold;
  assign cnt_inc[2] = flush_d | flush_e;

  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < 3; c++) begin
      if (cnt_clr) begin
        cnt_d[c] = '0;
      end else if (cnt_inc[c] && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_ldstall = cnt_q[0];
  assign cnt_mcstall = cnt_q[1];
  assign cnt_flush   = cnt_q[2];

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Three hazard units (MC_LAT 3/1/5, last with 4-bit counters) on shared stimulus;
// expected values are queued per step and compared by a negedge monitor.
module tb_hazard_unit_mc;

  localparam int NSRC = 4;
  localparam int NWP  = 2;
  localparam int AW   = 4;
  localparam int SW   = 3;

  localparam int S_FWD = 0, S_STF = 1, S_STD = 2, S_FLD = 3, S_FLE = 4;
  localparam int S_FLM = 5, S_HOLD = 6, S_CLD = 7, S_CMC = 8, S_CFL = 9;

  string sname [10] = '{"fwd_sel_e", "stall_f", "stall_d", "flush_d", "flush_e",
                        "flush_m", "mc_hold", "cnt_ldstall", "cnt_mcstall", "cnt_flush"};
  string dname [3]  = '{"lat3", "lat1", "lat5_cnt4"};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NSRC*AW-1:0]  src_addr_d, src_addr_e;
  logic [NSRC-1:0]     src_valid_d, src_valid_e;
  logic [NWP*AW-1:0]   dst_addr_e, dst_addr_m, dst_addr_w;
  logic [NWP-1:0]      wr_en_e, wr_en_m, wr_en_w;
  logic                mem_to_reg_e, mc_start_e, branch_taken_e, pcsrc_w, cnt_clr;
  logic [2:0]          pc_wr_pending;

  logic [NSRC*SW-1:0]  fwd [3];
  logic                stf [3], std [3], fld [3], fle [3], flm [3], hold [3];
  logic [15:0]         cla, cma, cfa, clb, cmb, cfb;
  logic [3:0]          clc, cmc, cfc;

  hazard_unit_mc #(.NSRC(NSRC), .NWP(NWP), .AW(AW), .MC_LAT(3), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .src_addr_d(src_addr_d), .src_valid_d(src_valid_d),
    .src_addr_e(src_addr_e), .src_valid_e(src_valid_e), .dst_addr_e(dst_addr_e),
    .dst_addr_m(dst_addr_m), .dst_addr_w(dst_addr_w), .wr_en_e(wr_en_e),
    .wr_en_m(wr_en_m), .wr_en_w(wr_en_w), .mem_to_reg_e(mem_to_reg_e),
    .mc_start_e(mc_start_e), .branch_taken_e(branch_taken_e),
    .pc_wr_pending(pc_wr_pending), .pcsrc_w(pcsrc_w), .fwd_sel_e(fwd[0]),
    .stall_f(stf[0]), .stall_d(std[0]), .flush_d(fld[0]), .flush_e(fle[0]),
    .flush_m(flm[0]), .mc_hold(hold[0]), .cnt_ldstall(cla), .cnt_mcstall(cma),
    .cnt_flush(cfa), .cnt_clr(cnt_clr));

  hazard_unit_mc #(.NSRC(NSRC), .NWP(NWP), .AW(AW), .MC_LAT(1), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .src_addr_d(src_addr_d), .src_valid_d(src_valid_d),
    .src_addr_e(src_addr_e), .src_valid_e(src_valid_e), .dst_addr_e(dst_addr_e),
    .dst_addr_m(dst_addr_m), .dst_addr_w(dst_addr_w), .wr_en_e(wr_en_e),
    .wr_en_m(wr_en_m), .wr_en_w(wr_en_w), .mem_to_reg_e(mem_to_reg_e),
    .mc_start_e(mc_start_e), .branch_taken_e(branch_taken_e),
    .pc_wr_pending(pc_wr_pending), .pcsrc_w(pcsrc_w), .fwd_sel_e(fwd[1]),
    .stall_f(stf[1]), .stall_d(std[1]), .flush_d(fld[1]), .flush_e(fle[1]),
    .flush_m(flm[1]), .mc_hold(hold[1]), .cnt_ldstall(clb), .cnt_mcstall(cmb),
    .cnt_flush(cfb), .cnt_clr(cnt_clr));

  hazard_unit_mc #(.NSRC(NSRC), .NWP(NWP), .AW(AW), .MC_LAT(5), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .src_addr_d(src_addr_d), .src_valid_d(src_valid_d),
    .src_addr_e(src_addr_e), .src_valid_e(src_valid_e), .dst_addr_e(dst_addr_e),
    .dst_addr_m(dst_addr_m), .dst_addr_w(dst_addr_w), .wr_en_e(wr_en_e),
    .wr_en_m(wr_en_m), .wr_en_w(wr_en_w), .mem_to_reg_e(mem_to_reg_e),
    .mc_start_e(mc_start_e), .branch_taken_e(branch_taken_e),
    .pc_wr_pending(pc_wr_pending), .pcsrc_w(pcsrc_w), .fwd_sel_e(fwd[2]),
    .stall_f(stf[2]), .stall_d(std[2]), .flush_d(fld[2]), .flush_e(fle[2]),
    .flush_m(flm[2]), .mc_hold(hold[2]), .cnt_ldstall(clc), .cnt_mcstall(cmc),
    .cnt_flush(cfc), .cnt_clr(cnt_clr));

  typedef struct {
    int          d;
    int          s;
    logic [31:0] exp;
    int          tag;
  } chk_t;

  chk_t sbq[$];
  int   step   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual(input int d, input int s);
    logic [31:0] r;
    r = '0;
    case (s)
      S_FWD:  r = 32'(fwd[d]);
      S_STF:  r = 32'(stf[d]);
      S_STD:  r = 32'(std[d]);
      S_FLD:  r = 32'(fld[d]);
      S_FLE:  r = 32'(fle[d]);
      S_FLM:  r = 32'(flm[d]);
      S_HOLD: r = 32'(hold[d]);
      S_CLD:  r = (d == 0) ? 32'(cla) : (d == 1) ? 32'(clb) : 32'(clc);
      S_CMC:  r = (d == 0) ? 32'(cma) : (d == 1) ? 32'(cmb) : 32'(cmc);
      S_CFL:  r = (d == 0) ? 32'(cfa) : (d == 1) ? 32'(cfb) : 32'(cfc);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic exp1(input int d, input int s, input logic [31:0] e);
    chk_t c;
    c.d = d; c.s = s; c.exp = e; c.tag = step;
    sbq.push_back(c);
  endtask

  task automatic exp3(input int s, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ec);
    exp1(0, s, ea);
    exp1(1, s, eb);
    exp1(2, s, ec);
  endtask

  // Monitor: every negedge, compare everything queued for the current step.
  initial begin
    chk_t        c;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        a = actual(c.d, c.s);
        n_chk++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL step %0d %s[%s]: got %0h, expected %0h",
                   c.tag, sname[c.s], dname[c.d], a, c.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic idle();
    src_addr_d = '0; src_valid_d = '0; src_addr_e = '0; src_valid_e = '0;
    dst_addr_e = '0; dst_addr_m = '0; dst_addr_w = '0;
    wr_en_e = '0; wr_en_m = '0; wr_en_w = '0;
    mem_to_reg_e = 1'b0; mc_start_e = 1'b0; branch_taken_e = 1'b0;
    pc_wr_pending = 3'b000; pcsrc_w = 1'b0; cnt_clr = 1'b0;
  endtask

  // Load in E writing r5 while D source 1 reads r5.
  task automatic set_ld();
    mem_to_reg_e = 1'b1;
    dst_addr_e   = 8'h05;
    wr_en_e      = 2'b01;
    src_addr_d   = 16'h0050;
    src_valid_d  = 4'b0010;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    cyc();  // reset state
    exp3(S_HOLD, 0, 0, 0); exp3(S_CLD, 0, 0, 0); exp3(S_CMC, 0, 0, 0);
    exp3(S_CFL, 0, 0, 0);  exp3(S_FWD, 0, 0, 0);

    cyc(); reset = 1'b0;  // forwarding: M1 beats W0, W1 hit, invalid source ignored
    src_addr_e = 16'h3373; src_valid_e = 4'b0111;
    dst_addr_m = 8'h30; wr_en_m = 2'b10; dst_addr_w = 8'h73; wr_en_w = 2'b11;
    exp3(S_FWD, 32'h0A2, 32'h0A2, 32'h0A2); exp3(S_STF, 0, 0, 0);

    cyc();  // r15 never forwarded
    src_addr_e = 16'h337F; dst_addr_m = 8'hF0; dst_addr_w = 8'h7F;
    exp3(S_FWD, 32'h020, 32'h020, 32'h020);

    cyc();  // M0 beats W1
    dst_addr_m = 8'hF7; wr_en_m = 2'b11;
    exp3(S_FWD, 32'h008, 32'h008, 32'h008);

    cyc(); idle(); set_ld();  // load-use
    exp3(S_STF, 1, 1, 1); exp3(S_STD, 1, 1, 1); exp3(S_FLE, 1, 1, 1);
    exp3(S_FLD, 0, 0, 0); exp3(S_FLM, 0, 0, 0); exp3(S_CLD, 0, 0, 0);

    cyc(); wr_en_e = 2'b00;  // load with no enabled destination
    exp3(S_STF, 0, 0, 0); exp3(S_FLE, 0, 0, 0);
    exp3(S_CLD, 1, 1, 1); exp3(S_CFL, 1, 1, 1);

    cyc(); idle(); mc_start_e = 1'b1;
    exp3(S_HOLD, 1, 0, 1); exp3(S_FLM, 1, 0, 1); exp3(S_STF, 1, 0, 1);

    cyc(); set_ld();  // load-use during hold
    exp3(S_HOLD, 1, 0, 1); exp3(S_FLE, 0, 1, 0); exp3(S_STD, 1, 1, 1);
    exp3(S_CLD, 1, 1, 1);

    cyc(); idle(); mc_start_e = 1'b1;  // release cycle for lat3
    exp3(S_HOLD, 0, 0, 1); exp3(S_CLD, 1, 2, 1); exp3(S_CFL, 1, 2, 1);

    cyc(); idle();
    exp3(S_HOLD, 0, 0, 1); exp3(S_CMC, 2, 0, 3);

    cyc();
    exp1(2, S_HOLD, 0); exp1(2, S_FLM, 0); exp3(S_CMC, 2, 0, 4);

    cyc(); set_ld(); branch_taken_e = 1'b1;
    exp3(S_FLD, 1, 1, 1); exp3(S_FLE, 1, 1, 1); exp3(S_STF, 1, 1, 1);

    cyc(); idle(); pc_wr_pending = 3'b010;
    exp3(S_STF, 1, 1, 1); exp3(S_STD, 0, 0, 0); exp3(S_FLD, 1, 1, 1);
    exp3(S_FLE, 0, 0, 0); exp3(S_CLD, 2, 3, 2);

    cyc(); idle(); pcsrc_w = 1'b1;
    exp3(S_FLD, 1, 1, 1); exp3(S_STF, 0, 0, 0);

    cyc(); idle();
    exp3(S_CFL, 4, 5, 4); exp3(S_CMC, 2, 0, 4);

    cyc(); mc_start_e = 1'b1;  // start hold, then reset on second hold cycle
    exp3(S_HOLD, 1, 0, 1);

    cyc(); idle(); reset = 1'b1; pcsrc_w = 1'b1;
    exp3(S_HOLD, 0, 0, 0); exp3(S_FLD, 1, 1, 1);

    cyc(); idle(); reset = 1'b0;
    exp3(S_HOLD, 0, 0, 0); exp3(S_CLD, 0, 0, 0); exp3(S_CMC, 0, 0, 0);
    exp3(S_CFL, 0, 0, 0);  exp3(S_STF, 0, 0, 0);

    for (int l = 1; l <= 20; l++) begin  // saturation run
      cyc(); mc_start_e = 1'b1;
      if (l == 1)  exp3(S_HOLD, 1, 0, 1);
      if (l == 19) exp1(2, S_CMC, 15);
    end

    cyc(); mc_start_e = 1'b0; cnt_clr = 1'b1;
    exp3(S_CMC, 14, 0, 15);

    cyc(); mc_start_e = 1'b1;  // clear while hold would increment
    exp3(S_CMC, 0, 0, 0); exp3(S_CFL, 0, 0, 0); exp3(S_HOLD, 1, 0, 1);

    cyc(); mc_start_e = 1'b0; cnt_clr = 1'b0;
    exp1(0, S_CMC, 0); exp1(0, S_HOLD, 1);

    cyc();
    exp1(0, S_CMC, 1); exp1(0, S_HOLD, 0); exp1(2, S_CMC, 1);

    cyc();
    cyc();
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
